pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in 1 (all state on rising edge); rst in 1 (synchronous, active-high).
REQ-002 NPC in 32 -- next fetch address from the next-PC unit.
REQ-003 PCWr in 1 -- PC write enable; 0 = pipeline stall.
REQ-004 PC_Flush in 1 -- redirect (branch/jump/exception/eret); valid only with PCWr=1.
REQ-005 inst_req out 1 -- instruction-memory request valid.
REQ-006 inst_addr out 32 -- request address.
REQ-007 inst_addr_ok in 1 -- memory accepted the address this cycle.
REQ-008 inst_data_ok in 1 -- read data valid this cycle.
REQ-009 inst_rdata in 32 -- read data.
REQ-010 IF_PC out 32 -- current fetch PC; the next-PC unit receives IF_PC+4 as pre_PC.
REQ-011 IF_Instr out 32 -- buffered instruction.
REQ-012 IF_valid out 1 -- IF_Instr/IF_PC valid to decode.
REQ-013 IF_ready in 1 -- decode accepts the instruction this cycle.
REQ-014 IF_adel out 1 -- fetch address error flag accompanying IF_valid.

Function
REQ-015 The block SHALL hold one PC register and allow at most one outstanding memory request.
REQ-016 The state machine SHALL have four states: REQ (inst_req=1, inst_addr=PC), WAIT (address accepted, awaiting data), HOLD (instruction buffered, IF_valid=1), CANCEL (awaiting data for a discarded request, inst_req=0).
REQ-017 REQ->WAIT on inst_addr_ok=1; otherwise remain in REQ with inst_req held and inst_addr stable.
REQ-018 WAIT->HOLD on inst_data_ok=1; IF_Instr<=inst_rdata; IF_valid=1 from the next cycle (minimum 2 cycles req-to-valid).
REQ-019 HOLD with IF_ready=1 and PCWr=1: PC<=NPC, IF_valid<=0, ->REQ. With IF_ready=0 or PCWr=0, hold all outputs.
REQ-020 PCWr=0 SHALL NOT block REQ->WAIT or WAIT->HOLD transitions; it blocks only PC update.
REQ-021 PC_Flush=1 with PCWr=1 SHALL have priority over every other event: PC<=NPC and IF_valid<=0 in all states.
REQ-022 Flush destinations: REQ without addr_ok -> REQ at the new PC; REQ with addr_ok in the same cycle -> CANCEL; WAIT without data_ok -> CANCEL; WAIT with data_ok in the same cycle -> REQ (data dropped); HOLD -> REQ; CANCEL with data_ok -> REQ; CANCEL without data_ok -> CANCEL.
REQ-023 CANCEL->REQ on inst_data_ok=1; the returned data SHALL never reach IF_Instr.
REQ-024 inst_data_ok in REQ or HOLD SHALL be ignored.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0x00000000 on the pre_PC path.

Reset
REQ-026 On rst=1 the block SHALL set PC=0xBFC00000, state=REQ, IF_valid=0, IF_Instr=0, and IF_adel=0.
REQ-027 inst_req SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-028 Reset during WAIT/CANCEL SHALL abandon the outstanding request; the memory is reset on the same signal.

Configuration
REQ-029 Macro FETCH_ADEL_EN defined: in REQ, if PC[1:0]!=0, the block SHALL assert no request and go directly to HOLD with IF_Instr=0 and IF_adel=1.
REQ-030 Macro FETCH_ADEL_EN undefined: IF_adel SHALL be tied 0, inst_addr[1:0] forced to 00, and PC[1:0] otherwise ignored.

Verification
REQ-031 Reset release, addr_ok on the first request, data_ok=0x24080001 the next cycle, IF_ready=1, NPC=0xBFC00004 -> inst_addr=0xBFC00000; IF_Instr=0x24080001 with IF_PC=0xBFC00000; next inst_addr=0xBFC00004.
REQ-032 HOLD with IF_ready=0 for 3 cycles -> IF_valid, IF_Instr, and IF_PC stable; inst_req=0; PC unchanged.
REQ-033 In WAIT, PC_Flush=1 with NPC=0xBFC00380; data_ok 2 cycles later with 0xDEADBEEF -> IF_valid never asserts with 0xDEADBEEF; the next request issues to 0xBFC00380.
REQ-034 In REQ, PC_Flush and addr_ok in the same cycle -> CANCEL; no new request until data_ok; then request to the new NPC.
REQ-035 PCWr=0 throughout a fetch -> fetch completes to HOLD; PC held until PCWr=1.
REQ-036 FETCH_ADEL_EN defined, NPC=0xBFC00002 taken -> inst_req stays 0; IF_valid=1, IF_adel=1, IF_Instr=0, IF_PC=0xBFC00002.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch stage: one PC register, at most one outstanding memory request.
// Optional macro FETCH_ADEL_EN enables misaligned fetch-address error reporting.
module pc_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        PCWr,
    input  logic        PC_Flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] pre_PC,
    output logic [31:0] IF_Instr,
    output logic        IF_valid,
    input  logic        IF_ready,
    output logic        IF_adel
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_CANCEL} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        flush;
    logic        misaligned;

    assign flush = PC_Flush & PCWr;

`ifdef FETCH_ADEL_EN
    assign misaligned = (pc[1:0] != 2'b00);
    assign inst_addr  = pc;
`else
    assign misaligned = 1'b0;
    assign inst_addr  = {pc[31:2], 2'b00};
`endif

    // Request is gated by rst so memory sees nothing while reset is held.
    assign inst_req = (state == S_REQ) && !misaligned && !rst;
    assign IF_PC    = pc;
    assign pre_PC   = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= 32'hBFC0_0000;
            IF_valid <= 1'b0;
            IF_Instr <= 32'h0;
            IF_adel  <= 1'b0;
        end else if (flush) begin
            pc       <= NPC;
            IF_valid <= 1'b0;
            IF_adel  <= 1'b0;
            // An accepted-but-unreturned request must be drained in CANCEL.
            case (state)
                S_REQ:            state <= (!misaligned && inst_addr_ok) ? S_CANCEL : S_REQ;
                S_WAIT, S_CANCEL: state <= inst_data_ok ? S_REQ : S_CANCEL;
                default:          state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (misaligned) begin
                        state    <= S_HOLD;
                        IF_valid <= 1'b1;
                        IF_Instr <= 32'h0;
                        IF_adel  <= 1'b1;
                    end else if (inst_addr_ok) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state    <= S_HOLD;
                        IF_valid <= 1'b1;
                        IF_Instr <= inst_rdata;
                        IF_adel  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (IF_ready && PCWr) begin
                        state    <= S_REQ;
                        pc       <= NPC;
                        IF_valid <= 1'b0;
                        IF_adel  <= 1'b0;
                    end
                end
                S_CANCEL: begin
                    if (inst_data_ok) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, hand sequences and a random run
// against a request/outstanding/discard reference model.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] NPC = 32'h0;
    logic        PCWr = 1'b0;
    logic        PC_Flush = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic [31:0] IF_PC;
    logic [31:0] pre_PC;
    logic [31:0] IF_Instr;
    logic        IF_valid;
    logic        IF_ready = 1'b0;
    logic        IF_adel;

    int total = 0;
    int bad   = 0;

    pc_fetch dut (
        .clk(clk), .rst(rst), .NPC(NPC), .PCWr(PCWr), .PC_Flush(PC_Flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .IF_PC(IF_PC),
        .pre_PC(pre_PC), .IF_Instr(IF_Instr), .IF_valid(IF_valid),
        .IF_ready(IF_ready), .IF_adel(IF_adel)
    );

    always #5 clk = ~clk;

    // Reference model: is a request in flight, is its data to be dropped,
    // is an instruction buffered for decode.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_out, m_disc, m_valid;

    task automatic model_step();
        bit acc, ret, fl, hs, out_n;
        if (rst) begin
            m_pc = 32'hBFC0_0000; m_instr = 32'h0;
            m_out = 0; m_disc = 0; m_valid = 0;
        end else begin
            acc   = !m_valid && !m_out && inst_addr_ok;
            ret   = m_out && inst_data_ok;
            fl    = PC_Flush && PCWr;
            hs    = m_valid && IF_ready && PCWr;
            out_n = (m_out && !ret) || acc;
            if (ret && !m_disc && !fl) begin
                m_valid = 1; m_instr = inst_rdata;
            end
            if (fl)       m_disc = out_n;
            else if (ret) m_disc = 0;
            m_out = out_n;
            if (fl || hs) begin
                m_pc = NPC; m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        bit exp_req;
        exp_req = !m_valid && !m_out && !rst;
        chk("rnd_req", {31'h0, inst_req}, {31'h0, exp_req});
        if (exp_req) chk("rnd_addr", inst_addr, m_pc & 32'hFFFF_FFFC);
        chk("rnd_valid", {31'h0, IF_valid}, {31'h0, m_valid});
        chk("rnd_pc", IF_PC, m_pc);
        chk("rnd_prepc", pre_PC, m_pc + 32'd4);
        if (m_valid) chk("rnd_instr", IF_Instr, m_instr);
        chk("rnd_adel", {31'h0, IF_adel}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] npc;
        logic        pcwr, flush, aok, dok;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // npc, pcwr, flush, aok, dok, rdata, rdy | req, addr, valid, pc, instr
        tbl.push_back('{32'hBFC00004, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00000, 32'h0});
        tbl.push_back('{32'hBFC00004, 1, 0, 0, 1, 32'h24080001, 0, 0, 32'h0,        1, 32'hBFC00000, 32'h24080001});
        tbl.push_back('{32'hBFC00004, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 32'hBFC00000, 32'h24080001});
        tbl.push_back('{32'hBFC00004, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 32'hBFC00000, 32'h24080001});
        tbl.push_back('{32'hBFC00004, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,        1, 32'hBFC00000, 32'h24080001});
        tbl.push_back('{32'hBFC00004, 1, 0, 0, 0, 32'h0,        1, 1, 32'hBFC00004, 0, 32'hBFC00004, 32'h0});
        tbl.push_back('{32'hBFC00008, 1, 0, 0, 0, 32'h0,        1, 1, 32'hBFC00004, 0, 32'hBFC00004, 32'h0});
        tbl.push_back('{32'hBFC00008, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00004, 32'h0});
        tbl.push_back('{32'hBFC00380, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00380, 32'h0});
        tbl.push_back('{32'hBFC00380, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC00380, 32'h0});
        tbl.push_back('{32'hBFC00384, 1, 0, 0, 1, 32'hDEADBEEF, 1, 1, 32'hBFC00380, 0, 32'hBFC00380, 32'h0});
        tbl.push_back('{32'hBFC00100, 1, 1, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00100, 32'h0});
        tbl.push_back('{32'hBFC00104, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00100, 32'h0});
        tbl.push_back('{32'hBFC00104, 1, 0, 0, 1, 32'h00000BAD, 0, 1, 32'hBFC00100, 0, 32'hBFC00100, 32'h0});
        tbl.push_back('{32'hBFC00200, 0, 0, 1, 0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC00100, 32'h0});
        tbl.push_back('{32'hBFC00200, 0, 0, 0, 1, 32'h11112222, 1, 0, 32'h0,        1, 32'hBFC00100, 32'h11112222});
        tbl.push_back('{32'hBFC00200, 0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00100, 32'h11112222});
        tbl.push_back('{32'hBFC00200, 0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hBFC00100, 32'h11112222});
        tbl.push_back('{32'hBFC00200, 1, 0, 0, 0, 32'h0,        1, 1, 32'hBFC00200, 0, 32'hBFC00200, 32'h0});
        tbl.push_back('{32'hBFC00204, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00200, 32'h0});
        tbl.push_back('{32'hFFFFFFFC, 1, 1, 0, 1, 32'hDEADDEAD, 0, 1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h0});

        // Reset state and request gating while rst is high
        rst = 1'b1;
        tick(); tick();
        chk("rst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_valid", {31'h0, IF_valid}, 32'h0);
        chk("rst_instr", IF_Instr, 32'h0);
        chk("rst_adel", {31'h0, IF_adel}, 32'h0);
        chk("rst_pc", IF_PC, 32'hBFC00000);
        rst = 1'b0;
        #1;
        chk("first_req", {31'h0, inst_req}, 32'h1);
        chk("first_addr", inst_addr, 32'hBFC00000);

        foreach (tbl[i]) begin
            NPC = tbl[i].npc; PCWr = tbl[i].pcwr; PC_Flush = tbl[i].flush;
            inst_addr_ok = tbl[i].aok; inst_data_ok = tbl[i].dok;
            inst_rdata = tbl[i].rdata; IF_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_req", i), {31'h0, inst_req}, {31'h0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), inst_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, IF_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("vec%0d_pc", i), IF_PC, tbl[i].e_pc);
            if (tbl[i].e_valid) chk($sformatf("vec%0d_instr", i), IF_Instr, tbl[i].e_instr);
        end
        chk("prepc_wrap", pre_PC, 32'h0);

`ifndef FETCH_ADEL_EN
        // Low PC bits never reach the memory address
        NPC = 32'h00000007; PCWr = 1'b1; PC_Flush = 1'b1;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; IF_ready = 1'b0;
        tick();
        chk("force_pc", IF_PC, 32'h00000007);
        chk("force_addr", inst_addr, 32'h00000004);
        chk("force_adel", {31'h0, IF_adel}, 32'h0);
`endif

        PC_Flush = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(99) == 0);
            NPC          = $urandom;
`ifdef FETCH_ADEL_EN
            NPC          = NPC & 32'hFFFF_FFFC;
`endif
            PCWr         = ($urandom_range(9) < 8);
            PC_Flush     = ($urandom_range(9) == 0);
            inst_addr_ok = 1'($urandom_range(1));
            inst_data_ok = ($urandom_range(9) < 4);
            inst_rdata   = $urandom;
            IF_ready     = ($urandom_range(9) < 6);
            tick();
            chk_model();
        end

`ifdef FETCH_ADEL_EN
        rst = 1'b1; PC_Flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        tick();
        rst = 1'b0; NPC = 32'hBFC00002; PCWr = 1'b1; PC_Flush = 1'b1;
        tick();
        chk("adel_noreq", {31'h0, inst_req}, 32'h0);
        PC_Flush = 1'b0; IF_ready = 1'b0; inst_addr_ok = 1'b1;
        tick();
        chk("adel_valid", {31'h0, IF_valid}, 32'h1);
        chk("adel_flag", {31'h0, IF_adel}, 32'h1);
        chk("adel_instr", IF_Instr, 32'h0);
        chk("adel_pc", IF_PC, 32'hBFC00002);
        chk("adel_req", {31'h0, inst_req}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
